// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked sharing of one uart_tx among NUM_REQ requesters; byte accepted in IDLE/HOLD,
// tx_valid_o from the next cycle until tx_done_i; requesters are backpressured by req_ready_o (one winner per cycle).
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rstn_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*8-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_done_i,
  input  logic [31:0]            frame_to_i,
  input  logic [31:0]            gap_to_i,
  output logic [1:0]             err_o,
  input  logic                   err_clr_i
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, r_owner;
  logic            r_last;
  logic [7:0]      r_tx_data;
  logic [31:0]     r_frame_cnt, r_gap_cnt;
  logic [1:0]      r_err;

  logic [IW-1:0]   w_win, w_cand, w_sel;
  logic            w_win_vld;
  int              w_idx;
  logic            w_accept, w_release, w_set_frame_err, w_set_gap_err;
  logic [NUM_REQ-1:0] w_ready;

  // First valid requester scanning upward from the rr pointer with wrap.
  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    w_idx     = 0;
    w_cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      w_cand = IW'(w_idx);
      if (!w_win_vld && req_valid_i[w_cand]) begin
        w_win     = w_cand;
        w_win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    w_release       = 1'b0;
    w_set_frame_err = 1'b0;
    w_set_gap_err   = 1'b0;
    w_sel           = w_win;
    w_ready         = '0;
    case (r_state)
      S_IDLE: begin
        if (rstn_i && w_win_vld) begin
          w_accept       = 1'b1;
          w_ready[w_win] = 1'b1;
          w_state_nxt    = S_SEND;
        end
      end
      S_SEND: begin
        // A completed frame outranks a timeout landing on the same cycle.
        if (tx_done_i) begin
          if (r_last) begin
            w_release   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end else if (frame_to_i != 32'd0 && r_frame_cnt == frame_to_i - 32'd1) begin
          w_set_frame_err = 1'b1;
          w_release       = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      S_HOLD: begin
        w_sel = r_owner;
        if (req_valid_i[r_owner]) begin
          w_accept         = 1'b1;
          w_ready[r_owner] = 1'b1;
          w_state_nxt      = S_SEND;
        end else if (gap_to_i != 32'd0 && r_gap_cnt == gap_to_i - 32'd1) begin
          w_set_gap_err = 1'b1;
          w_release     = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_last      <= 1'b0;
      r_tx_data   <= 8'h00;
      r_frame_cnt <= 32'd0;
      r_gap_cnt   <= 32'd0;
      r_err       <= 2'b00;
    end else begin
      if (w_accept) begin
        r_tx_data <= req_data_i[{w_sel, 3'b000} +: 8];
        r_last    <= req_last_i[w_sel];
        r_owner   <= w_sel;
      end
      if (w_release)
        r_ptr <= (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
      if (w_state_nxt != r_state) begin
        r_frame_cnt <= 32'd0;
        r_gap_cnt   <= 32'd0;
      end else if (r_state == S_SEND) begin
        r_frame_cnt <= r_frame_cnt + 32'd1;
      end else if (r_state == S_HOLD) begin
        r_gap_cnt <= r_gap_cnt + 32'd1;
      end
      // Set wins over a simultaneous clear.
      r_err <= (err_clr_i ? 2'b00 : r_err) | {w_set_gap_err, w_set_frame_err};
    end
  end

  assign req_ready_o = w_ready;
  assign tx_valid_o  = (r_state == S_SEND);
  assign tx_data_o   = r_tx_data;
  assign busy_o      = (r_state != S_IDLE);
  assign grant_o     = busy_o ? (NUM_REQ'(1) << r_owner) : '0;
  assign err_o       = r_err;

endmodule
